// File: rtl/prog_loader_pkg.sv
// Shared sizes, FSM state encoding and the word-count clamp for the program loader.
package prog_loader_pkg;
    localparam int ADR_W  = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FINISH} state_t;

    // Counts above the memory depth would revisit words, so cap at one full pass.
    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : c;
    endfunction
endpackage

// File: rtl/sum32_acc.sv
// 32-bit wrap-around accumulator with synchronous clear and add enable.
module sum32_acc
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] op,
    output logic [DATA_W-1:0] sum
);
    always_ff @(posedge clk) begin
        if (!rst_n)   sum <= '0;
        else if (clr) sum <= '0;
        else if (en)  sum <= sum + op;
    end
endmodule

// File: rtl/prog_loader.sv
// Streams a block of words into a 64x32 memory, optionally reads it back and
// compares write/read checksums before signalling done.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter bit VERIFY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADR_W-1:0]  base_adr,
    input  logic [CNT_W-1:0]  word_cnt,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t            state;
    logic [ADR_W-1:0]  ptr, base_q;
    logic [CNT_W-1:0]  remain, cnt_q, cnt_in;
    logic [DATA_W-1:0] wsum, rsum;
    logic              hs, load_go;

    assign cnt_in  = clamp_cnt(word_cnt);
    assign hs      = (state == WRITE) && s_valid;
    assign load_go = (state == IDLE) && start && (cnt_in != '0);

    assign s_ready = (state == WRITE);
    assign mem_we  = hs;
    assign mem_adr = ptr;
    assign mem_wd  = (state == WRITE) ? s_data : '0;
    assign busy    = (state != IDLE);

    sum32_acc u_wsum (.clk(clk), .rst_n(rst_n), .clr(load_go), .en(hs),
                      .op(s_data), .sum(wsum));
    sum32_acc u_rsum (.clk(clk), .rst_n(rst_n), .clr(load_go), .en(state == VERIFY),
                      .op(mem_rd), .sum(rsum));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            base_q <= '0;
            remain <= '0;
            cnt_q  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    err <= 1'b0;
                    if (cnt_in == '0) begin
                        done <= 1'b1;
                    end else begin
                        base_q <= base_adr;
                        cnt_q  <= cnt_in;
                        ptr    <= base_adr;
                        remain <= cnt_in;
                        state  <= WRITE;
                    end
                end
                WRITE: if (s_valid) begin
                    ptr    <= ptr + ADR_W'(1);
                    remain <= remain - CNT_W'(1);
                    if (remain == CNT_W'(1)) begin
                        if (VERIFY_EN) begin
                            state  <= VERIFY;
                            ptr    <= base_q;
                            remain <= cnt_q;
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                VERIFY: begin
                    ptr    <= ptr + ADR_W'(1);
                    remain <= remain - CNT_W'(1);
                    if (remain == CNT_W'(1)) begin
                        // done/err are raised on entry so they are visible during FINISH;
                        // the last read word is folded in here rather than waiting a cycle.
                        state <= FINISH;
                        done  <= 1'b1;
                        err   <= (wsum != rsum + mem_rd);
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
